// File: rtl/ctrl_encode_def.sv
// ALUOp encodings shared by the control FSM and the ALU.
// Build option: define ALU_OVF_EN to enable the ADD/SUB signed-overflow flag.
package ctrl_encode_def;

   typedef enum logic [4:0] {
      ALU_NOP   = 5'd0,
      ALU_ADD   = 5'd1,
      ALU_SUB   = 5'd2,
      ALU_AND   = 5'd3,
      ALU_OR    = 5'd4,
      ALU_SLT   = 5'd5,
      ALU_SLTU  = 5'd6,
      ALU_NOR   = 5'd7,
      ALU_SLL   = 5'd8,
      ALU_LUI   = 5'd9,
      ALU_SRL   = 5'd10,
      ALU_SRA   = 5'd11,
      ALU_XOR   = 5'd12,
      ALU_MULT  = 5'd16,
      ALU_MULTU = 5'd17,
      ALU_DIV   = 5'd18,
      ALU_DIVU  = 5'd19,
      ALU_MFHI  = 5'd20,
      ALU_MFLO  = 5'd21,
      ALU_MTHI  = 5'd22,
      ALU_MTLO  = 5'd23
   } alu_op_e;

`ifdef ALU_OVF_EN
   localparam bit ALU_OVF_ON = 1'b1;
`else
   localparam bit ALU_OVF_ON = 1'b0;
`endif

   function automatic logic is_muldiv(input alu_op_e op);
      return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
   endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO registers.
// One result bit per cycle; signed ops run on magnitudes and fix the sign on the last edge.
module alu_muldiv
   import ctrl_encode_def::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e           r_state, w_state_n;
   logic [CW-1:0]    r_cnt;
   logic             r_is_div, r_dz_op, r_neg_lo, r_neg_hi, r_dz;
   logic [WIDTH-1:0] r_rem, r_quo, r_mcand, r_hi, r_lo;

   logic             w_accept, w_last, w_signed, w_div_op, w_b_zero, w_a_neg, w_b_neg, w_ge;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_n, w_quo_n;
   logic [WIDTH:0]   w_add, w_shl, w_sub;
   logic [2*WIDTH-1:0] w_prod;

   assign w_accept = start && (r_state == S_IDLE) && is_muldiv(op);
   assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
   assign w_signed = (op == ALU_MULT) || (op == ALU_DIV);
   assign w_div_op = (op == ALU_DIV) || (op == ALU_DIVU);
   assign w_b_zero = (b == '0);
   assign w_a_neg  = w_signed && a[WIDTH-1];
   assign w_b_neg  = w_signed && b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -a : a;
   assign w_b_mag  = w_b_neg ? -b : b;

   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_state_n = S_RUN;
         S_RUN:   if (w_last)   w_state_n = S_DONE;
         default: w_state_n = S_IDLE;
      endcase
   end

   // Multiply: {r_rem,r_quo} shifts right as partial sums enter the top half.
   // Divide: {r_rem,r_quo} shifts left, quotient bits enter at the bottom.
   assign w_add = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_mcand} : '0);
   assign w_shl = {r_rem, r_quo[WIDTH-1]};
   assign w_ge  = (w_shl >= {1'b0, r_mcand});
   assign w_sub = w_shl - {1'b0, r_mcand};

   always_comb begin
      if (r_is_div) begin
         w_rem_n = w_ge ? w_sub[WIDTH-1:0] : w_shl[WIDTH-1:0];
         w_quo_n = {r_quo[WIDTH-2:0], w_ge};
      end else begin
         w_rem_n = w_add[WIDTH:1];
         w_quo_n = {w_add[0], r_quo[WIDTH-1:1]};
      end
   end

   assign w_prod = r_neg_lo ? -{w_rem_n, w_quo_n} : {w_rem_n, w_quo_n};

   // NOTE: sequential state uses non-blocking assignments and a synchronous reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_dz_op  <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_dz     <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_mcand  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_accept) begin
            r_is_div <= w_div_op;
            r_dz_op  <= w_div_op && w_b_zero;
            r_cnt    <= (w_div_op && w_b_zero) ? CW'(WIDTH - 1) : '0;
            r_rem    <= (w_div_op && w_b_zero) ? a : '0;
            r_quo    <= w_a_mag;
            r_mcand  <= w_b_mag;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            if (w_div_op) r_dz <= w_b_zero;
         end else if (r_state == S_RUN) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            if (w_last) begin
               if (r_dz_op) begin
                  r_hi <= r_rem;
                  r_lo <= '1;
               end else if (r_is_div) begin
                  r_hi <= r_neg_hi ? -w_rem_n : w_rem_n;
                  r_lo <= r_neg_lo ? -w_quo_n : w_quo_n;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
            end
         end
         if (start && (r_state != S_RUN) && (op == ALU_MTHI)) r_hi <= a;
         if (start && (r_state != S_RUN) && (op == ALU_MTLO)) r_lo <= a;
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign dz   = r_dz;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: combinational ops plus the iterative mul/div unit with HI/LO.
// Build option: ALU_OVF_EN enables the ADD/SUB signed-overflow output (tied 0 otherwise).
module alu_md
   import ctrl_encode_def::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 5,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPW-1:0]   ALUOp,
   input  logic             start,
   output logic [WIDTH-1:0] C,
   output logic             Zero,
   output logic             Overflow,
   output logic             busy,
   output logic             done,
   output logic             dz,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   alu_op_e          w_op;
   logic [SHW-1:0]   w_sh;
   logic [WIDTH-1:0] w_sum, w_diff, w_c;

   assign w_op   = alu_op_e'(ALUOp[4:0]);
   assign w_sh   = A[SHW-1:0];
   assign w_sum  = A + B;
   assign w_diff = A - B;

   alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk   (clk),
      .rstn  (rstn),
      .start (start),
      .op    (w_op),
      .a     (A),
      .b     (B),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .hi    (hi),
      .lo    (lo)
   );

   // Multi-cycle, move-to and undefined codes all pass A through.
   always_comb begin
      w_c = A;
      case (w_op)
         ALU_ADD:  w_c = w_sum;
         ALU_SUB:  w_c = w_diff;
         ALU_AND:  w_c = A & B;
         ALU_OR:   w_c = A | B;
         ALU_XOR:  w_c = A ^ B;
         ALU_NOR:  w_c = ~(A | B);
         ALU_SLT:  w_c = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
         ALU_SLTU: w_c = {{(WIDTH-1){1'b0}}, A < B};
         ALU_SLL:  w_c = B << w_sh;
         ALU_SRL:  w_c = B >> w_sh;
         ALU_SRA:  w_c = WIDTH'($signed(B) >>> w_sh);
         ALU_LUI:  w_c = B << (WIDTH / 2);
         ALU_MFHI: w_c = hi;
         ALU_MFLO: w_c = lo;
         default:  w_c = A;
      endcase
   end

   assign C    = w_c;
   assign Zero = (w_c == '0);

`ifdef ALU_OVF_EN
   always_comb begin
      Overflow = 1'b0;
      if (w_op == ALU_ADD)
         Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      else if (w_op == ALU_SUB)
         Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
   end
`else
   assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): table of combinational vectors plus
// hand-written mul/div, divide-by-zero, ignored-start, reset-abort and MTHI/MTLO sequences.
module tb_alu_md;

   localparam logic [4:0] OP_NOP = 5'd0,  OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3;
   localparam logic [4:0] OP_OR  = 5'd4,  OP_SLT = 5'd5,  OP_SLTU = 5'd6, OP_NOR = 5'd7;
   localparam logic [4:0] OP_SLL = 5'd8,  OP_LUI = 5'd9,  OP_SRL = 5'd10, OP_SRA = 5'd11;
   localparam logic [4:0] OP_XOR = 5'd12, OP_MULT = 5'd16, OP_MULTU = 5'd17;
   localparam logic [4:0] OP_DIV = 5'd18, OP_DIVU = 5'd19, OP_MFHI = 5'd20;
   localparam logic [4:0] OP_MFLO = 5'd21, OP_MTHI = 5'd22, OP_MTLO = 5'd23;

`ifdef ALU_OVF_EN
   localparam logic OVF = 1'b1;
`else
   localparam logic OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn, start, Zero, Overflow, busy, done, dz;
   logic [31:0] A, B, C, hi, lo;
   logic [4:0]  ALUOp;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a, b, c;
      logic        z, v;
   } vec_t;

   vec_t vecs[$];

   alu_md dut (
      .clk(clk), .rstn(rstn), .A(A), .B(B), .ALUOp(ALUOp), .start(start),
      .C(C), .Zero(Zero), .Overflow(Overflow), .busy(busy), .done(done),
      .dz(dz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a, b,
                         input logic [31:0] exp_hi, exp_lo, input logic exp_dz,
                         input int exp_cyc, input bit inject);
      int cnt;
      ALUOp = op; A = a; B = b; start = 1'b1;
      tick();
      start = 1'b0;
      check({name, " C=A while busy"}, C, a);
      A = $urandom; B = $urandom;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         start = inject && (cnt == 5);
         tick();
      end
      start = 1'b0;
      check({name, " busy cycles"}, cnt, exp_cyc);
      check({name, " done"}, {31'd0, done}, 32'd1);
      check({name, " hi"}, hi, exp_hi);
      check({name, " lo"}, lo, exp_lo);
      check({name, " dz"}, {31'd0, dz}, {31'd0, exp_dz});
      tick();
      check({name, " done drops"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int dones;

      vecs.push_back('{"nop",        OP_NOP,  32'h12345678, 32'h0,        32'h12345678, 1'b0, 1'b0});
      vecs.push_back('{"add",        OP_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0});
      vecs.push_back('{"add ovf",    OP_ADD,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, OVF});
      vecs.push_back('{"sub neg",    OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0});
      vecs.push_back('{"sub zero",   OP_SUB,  32'd5,        32'd5,        32'h0,        1'b1, 1'b0});
      vecs.push_back('{"sub ovf",    OP_SUB,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, OVF});
      vecs.push_back('{"and",        OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
      vecs.push_back('{"or",         OP_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0});
      vecs.push_back('{"xor",        OP_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0});
      vecs.push_back('{"nor",        OP_NOR,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0,        1'b1, 1'b0});
      vecs.push_back('{"slt",        OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0});
      vecs.push_back('{"sltu",       OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0});
      vecs.push_back('{"sltu false", OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0});
      vecs.push_back('{"sll",        OP_SLL,  32'd4,        32'h0000000F, 32'h000000F0, 1'b0, 1'b0});
      vecs.push_back('{"srl",        OP_SRL,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0});
      vecs.push_back('{"sra",        OP_SRA,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0});
      vecs.push_back('{"sra shamt5", OP_SRA,  32'd36,       32'h7FFFFFFF, 32'h07FFFFFF, 1'b0, 1'b0});
      vecs.push_back('{"lui",        OP_LUI,  32'h0,        32'h00001234, 32'h12340000, 1'b0, 1'b0});
      vecs.push_back('{"undef op",   5'd13,   32'hCAFEBABE, 32'h1,        32'hCAFEBABE, 1'b0, 1'b0});
      vecs.push_back('{"mult nostart", OP_MULT, 32'h00000042, 32'h5,      32'h00000042, 1'b0, 1'b0});

      rstn = 1'b0; start = 1'b0; ALUOp = OP_NOP; A = '0; B = '0;
      tick(); tick();
      check("reset hi", hi, 32'h0);
      check("reset lo", lo, 32'h0);
      check("reset busy/done/dz", {29'd0, busy, done, dz}, 32'h0);
      rstn = 1'b1;
      tick();

      foreach (vecs[i]) begin
         ALUOp = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
         #1;
         check({vecs[i].name, " C"}, C, vecs[i].c);
         check({vecs[i].name, " Zero"}, {31'd0, Zero}, {31'd0, vecs[i].z});
         check({vecs[i].name, " Ovf"}, {31'd0, Overflow}, {31'd0, vecs[i].v});
      end
      check("comb busy idle", {31'd0, busy}, 32'd0);
      tick();

      run_md("mult -3*7",  OP_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32, 1'b0);
      run_md("multu",      OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 32, 1'b0);
      run_md("div -7/2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32, 1'b0);
      run_md("div min/-1", OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 32, 1'b0);
      run_md("divu 5/0",   OP_DIVU,  32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 1'b0);
      run_md("divu 9/3",   OP_DIVU,  32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 32, 1'b0);
      run_md("div 7/-2",   OP_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 32, 1'b0);
      run_md("mult inject", OP_MULT, 32'd1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFC18, 1'b0, 32, 1'b1);

      // Start held during the done cycle must not launch a new operation.
      ALUOp = OP_MULTU; A = 32'd3; B = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      check("start in idle busy", {31'd0, busy}, 32'd1);
      while (busy && n_total < 100000) tick();
      start = 1'b1; A = 32'd5;
      check("lo 3*3", lo, 32'd9);
      tick();
      start = 1'b0;
      check("start during done ignored", {31'd0, busy}, 32'd0);
      tick();

      // Reset at busy cycle 10 aborts the operation with no done pulse.
      ALUOp = OP_MULT; A = 32'd3; B = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check("busy before abort", {31'd0, busy}, 32'd1);
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort hi", hi, 32'h0);
      check("abort lo", lo, 32'h0);
      dones = 0;
      repeat (40) begin
         if (done) dones++;
         tick();
      end
      check("abort no done", dones, 0);

      ALUOp = OP_MTHI; A = 32'h1234; start = 1'b1;
      tick();
      start = 1'b0;
      check("mthi hi", hi, 32'h1234);
      check("mthi no busy/done", {30'd0, busy, done}, 32'd0);
      ALUOp = OP_MTLO; A = 32'h55AA; start = 1'b1;
      tick();
      start = 1'b0;
      check("mtlo lo", lo, 32'h55AA);
      check("mtlo hi kept", hi, 32'h1234);
      ALUOp = OP_MFHI; A = 32'h0;
      #1;
      check("mfhi C", C, 32'h1234);
      ALUOp = OP_MFLO;
      #1;
      check("mflo C", C, 32'h55AA);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised ALU for the multicycle CPU datapath.
- Single-cycle combinational ops, plus an iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage. The control FSM issues `start` for multi-cycle ops and holds in its execute state while `busy` is high.
- Adds over the previous ALU: XOR, SRA, MULT/MULTU/DIV/DIVU, MFHI/MFLO/MTHI/MTLO, WIDTH generalisation.

Parameters:
- WIDTH, 32: datapath width. Even, ≥8.
- OPW, 5: ALUOp width.
- SHW, $clog2(WIDTH): shift-amount bits, taken from A[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous active-low reset.
- A  in  WIDTH  operand A, signed; shift amount for shifts.
- B  in  WIDTH  operand B, signed.
- ALUOp  in  OPW  operation code.
- start  in  1  issue pulse for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- C  out  WIDTH  combinational result.
- Zero  out  1  C == 0.
- Overflow  out  1  signed overflow (see Optional Feature).
- busy  out  1  mul/div iteration in progress.
- done  out  1  one-cycle pulse: mul/div result written to HI/LO.
- dz  out  1  last DIV/DIVU had divisor 0; sticky until next DIV/DIVU accepted.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: rstn low at a rising edge → hi=lo=0, busy=0, done=0, dz=0, iteration counter=0. An in-flight operation is aborted and its result discarded. C is combinational and has no reset value.
- Combinational ops, C valid in the same cycle:
  - NOP: C=A.
  - ADD: C=A+B. SUB: C=A-B (wrap modulo 2^WIDTH).
  - AND, OR, XOR, NOR: bitwise.
  - SLT: signed compare. SLTU: unsigned compare. Result is 1 or 0.
  - SLL: C=B<<A[SHW-1:0]. SRL: logical right shift. SRA: arithmetic right shift.
  - LUI: C=B<<(WIDTH/2).
  - MFHI: C=hi. MFLO: C=lo.
  - Undefined codes: C=A.
- Multi-cycle ops: C=A during them. start with a non-issue op is ignored.
- Acceptance: start && !busy && !done at a rising edge, with ALUOp in {MULT, MULTU, DIV, DIVU}.
  - busy asserts in the next cycle and stays high exactly WIDTH cycles.
  - On the edge ending the last busy cycle, {hi,lo} load and busy drops.
  - done=1 for the following single cycle.
  - start→done latency is WIDTH+1 cycles.
- start while busy or done is ignored. No queueing; operands are not re-sampled.
- A and B are captured at acceptance and may change freely afterwards.
- MULT/MULTU: {hi,lo} = full 2·WIDTH-bit product, signed or unsigned. Implemented as radix-2 shift-add over magnitudes, with sign fix-up at the end for MULT.
- DIV/DIVU: lo=quotient, hi=remainder. Restoring division, one bit per cycle.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ -1: lo = most-negative, hi=0, no trap.
- Divide by zero (B==0 at acceptance):
  - busy high 1 cycle, then done.
  - hi=A, lo = all ones, dz=1.
- MTHI/MTLO with start && !busy: hi (or lo) = A at that edge. No busy, no done.
- Zero reflects the current C, including during busy.

Optional Feature:
- ALU_OVF_EN defined: Overflow = signed overflow of ADD/SUB (operand signs equal/different and result sign differs); 0 for all other ops.
- ALU_OVF_EN undefined: Overflow tied 0 and its logic is removed. The port remains.

Decomposition:
- Shared package ctrl_encode_def holds the ALUOp codes:
  - NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 7.
  - SLL 8, LUI 9, SRL 10, SRA 11, XOR 12.
  - MULT 16, MULTU 17, DIV 18, DIVU 19.
  - MFHI 20, MFLO 21, MTHI 22, MTLO 23.
- Package also holds ALU_OVF_EN.
- One sub-module, alu_muldiv: owns the iteration FSM (IDLE→RUN→DONE→IDLE), the counter, the operand/partial registers, hi/lo and dz.
- The top level keeps the combinational case, the C mux and the Zero/Overflow logic.

Test Plan (WIDTH=32):
- Combinational sweep: SRA with A=4, B=0x80000000 → C=0xF8000000. XOR with A=0xFF00FF00, B=0x0F0F0F0F → C=0xF00FF00F. SLTU with A=1, B=0xFFFFFFFF → C=1, Zero=0.
- MULT A=-3, B=7 with start → busy 32 cycles, done at cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, dz=0. DIV 0x80000000 ÷ -1 → lo=0x80000000, hi=0.
- DIVU A=5, B=0 → busy 1 cycle, then done, hi=5, lo=0xFFFFFFFF, dz=1. A following DIVU 9÷3 clears dz: lo=3, hi=0.
- Start pulse mid-busy with new operands → ignored, original result kept. rstn low at busy cycle 10 → busy=0, hi=lo=0, no done pulse. MTHI A=0x1234 → hi=0x1234 next cycle; MFHI then gives C=0x1234.
- With ALU_OVF_EN: ADD 0x7FFFFFFF+1 → Overflow=1, C=0x80000000. Without ALU_OVF_EN: the same add gives Overflow=0.
